// File: rtl/bellek_hakemi.sv
// Round-robin arbiter that shares the single main-memory port between the
// instruction-cache and data-cache miss paths, with an optional response timeout.
module bellek_hakemi #(
    parameter int ADRES_W     = 32,
    parameter int VERI_W      = 32,
    parameter int ZAMAN_ASIMI = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  bb_istek_i,
    input  logic [ADRES_W-1:0]    bb_adres_i,
    output logic [VERI_W-1:0]     bb_veri_o,
    output logic                  bb_hazir_o,

    input  logic                  vb_istek_i,
    input  logic                  vb_yaz_i,
    input  logic [ADRES_W-1:0]    vb_adres_i,
    input  logic [VERI_W-1:0]     vb_veri_i,
    input  logic [VERI_W/8-1:0]   vb_maske_i,
    output logic [VERI_W-1:0]     vb_veri_o,
    output logic                  vb_hazir_o,

    output logic                  bel_istek_o,
    output logic                  bel_yaz_o,
    output logic [ADRES_W-1:0]    bel_adres_o,
    output logic [VERI_W-1:0]     bel_veri_o,
    output logic [VERI_W/8-1:0]   bel_maske_o,
    input  logic [VERI_W-1:0]     bel_veri_i,
    input  logic                  bel_hazir_i,

    output logic                  zaman_asimi_o
);

    localparam int SW = VERI_W / 8;
    localparam int CW = (ZAMAN_ASIMI > 0) ? $clog2(ZAMAN_ASIMI + 1) : 1;

    // Counter value seen in the last permitted waiting cycle.
    localparam logic [CW-1:0] SON_SAYI   = (ZAMAN_ASIMI > 0) ? CW'(ZAMAN_ASIMI - 1) : '0;
    localparam logic [CW-1:0] SAYAC_TAVAN = '1;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        BUYRUK = 2'd1,
        VERI   = 2'd2,
        BITTI  = 2'd3
    } durum_t;

    durum_t          durum;
    logic            son_veri;   // 1: last grant went to the data side
    logic [CW-1:0]   sayac;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum         <= BOS;
            son_veri      <= 1'b0;
            sayac         <= '0;
            bb_veri_o     <= '0;
            bb_hazir_o    <= 1'b0;
            vb_veri_o     <= '0;
            vb_hazir_o    <= 1'b0;
            bel_istek_o   <= 1'b0;
            bel_yaz_o     <= 1'b0;
            bel_adres_o   <= '0;
            bel_veri_o    <= '0;
            bel_maske_o   <= '0;
            zaman_asimi_o <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    // On a tie the side that was not served last wins.
                    if (bb_istek_i && (!vb_istek_i || son_veri)) begin
                        durum       <= BUYRUK;
                        son_veri    <= 1'b0;
                        sayac       <= '0;
                        bel_istek_o <= 1'b1;
                        bel_yaz_o   <= 1'b0;
                        bel_adres_o <= bb_adres_i;
                        bel_veri_o  <= '0;
                        bel_maske_o <= {SW{1'b1}};
                    end else if (vb_istek_i) begin
                        durum       <= VERI;
                        son_veri    <= 1'b1;
                        sayac       <= '0;
                        bel_istek_o <= 1'b1;
                        bel_yaz_o   <= vb_yaz_i;
                        bel_adres_o <= vb_adres_i;
                        bel_veri_o  <= vb_veri_i;
                        bel_maske_o <= vb_yaz_i ? vb_maske_i : {SW{1'b1}};
                    end
                end

                BUYRUK, VERI: begin
                    if (bel_hazir_i) begin
                        bel_istek_o <= 1'b0;
                        durum       <= BITTI;
                        if (durum == BUYRUK) begin
                            bb_hazir_o <= 1'b1;
                            bb_veri_o  <= bel_veri_i;
                        end else begin
                            vb_hazir_o <= 1'b1;
                            vb_veri_o  <= bel_yaz_o ? '0 : bel_veri_i;
                        end
                    end else if ((ZAMAN_ASIMI != 0) && (sayac == SON_SAYI)) begin
                        bel_istek_o   <= 1'b0;
                        zaman_asimi_o <= 1'b1;
                        durum         <= BITTI;
                        if (durum == BUYRUK) begin
                            bb_hazir_o <= 1'b1;
                            bb_veri_o  <= '0;
                        end else begin
                            vb_hazir_o <= 1'b1;
                            vb_veri_o  <= '0;
                        end
                    end else if (sayac != SAYAC_TAVAN) begin
                        sayac <= sayac + 1'b1;
                    end
                end

                BITTI: begin
                    // Requests are deliberately not sampled here so the finished
                    // requester has a cycle to drop its level request.
                    durum         <= BOS;
                    bb_hazir_o    <= 1'b0;
                    bb_veri_o     <= '0;
                    vb_hazir_o    <= 1'b0;
                    vb_veri_o     <= '0;
                    zaman_asimi_o <= 1'b0;
                end

                default: durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Self-checking bench for bellek_hakemi: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_bellek_hakemi;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int ZA = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            bb_istek;
    logic [AW-1:0]   bb_adres;
    logic [DW-1:0]   bb_veri_o;
    logic            bb_hazir_o;
    logic            vb_istek;
    logic            vb_yaz;
    logic [AW-1:0]   vb_adres;
    logic [DW-1:0]   vb_veri;
    logic [SW-1:0]   vb_maske;
    logic [DW-1:0]   vb_veri_o;
    logic            vb_hazir_o;
    logic            bel_istek_o;
    logic            bel_yaz_o;
    logic [AW-1:0]   bel_adres_o;
    logic [DW-1:0]   bel_veri_o;
    logic [SW-1:0]   bel_maske_o;
    logic [DW-1:0]   bel_veri;
    logic            bel_hazir;
    logic            zaman_asimi_o;

    int checks = 0;
    int errors = 0;
    bit son_veri_m;   // model: last grant went to the data side

    always #5 clk = ~clk;

    bellek_hakemi #(.ADRES_W(AW), .VERI_W(DW), .ZAMAN_ASIMI(ZA)) dut (
        .clk_i(clk), .rst_i(rst),
        .bb_istek_i(bb_istek), .bb_adres_i(bb_adres), .bb_veri_o(bb_veri_o), .bb_hazir_o(bb_hazir_o),
        .vb_istek_i(vb_istek), .vb_yaz_i(vb_yaz), .vb_adres_i(vb_adres), .vb_veri_i(vb_veri),
        .vb_maske_i(vb_maske), .vb_veri_o(vb_veri_o), .vb_hazir_o(vb_hazir_o),
        .bel_istek_o(bel_istek_o), .bel_yaz_o(bel_yaz_o), .bel_adres_o(bel_adres_o),
        .bel_veri_o(bel_veri_o), .bel_maske_o(bel_maske_o), .bel_veri_i(bel_veri),
        .bel_hazir_i(bel_hazir), .zaman_asimi_o(zaman_asimi_o)
    );

    task automatic kontrol(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string where);
        kontrol({where, " bel_istek"}, bel_istek_o, 0);
        kontrol({where, " hazir"}, {bb_hazir_o, vb_hazir_o, zaman_asimi_o}, 0);
        kontrol({where, " veri_o"}, {bb_veri_o, vb_veri_o}, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_quiet("idle");
            bel_hazir = 1'($urandom_range(0, 1));
            bel_veri  = $urandom;
            step;
        end
        bel_hazir = 1'b0;
    endtask

    // Called in a BOS cycle; returns in the BOS cycle after the completion cycle.
    // d = high cycle (1-based) in which memory answers; d > ZA means memory stays silent.
    task automatic txn(input bit b_req, input bit v_req,
                       input logic [AW-1:0] badr, input logic [AW-1:0] vadr,
                       input logic [DW-1:0] vdat, input logic [SW-1:0] vmask,
                       input bit vyaz, input int d, input logic [DW-1:0] mdat);
        bit            w_veri;
        bit            tmo;
        bit            e_yaz;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_msk;
        logic [DW-1:0] e_out;

        bb_istek = bb_istek | b_req;
        vb_istek = vb_istek | v_req;
        if (!bb_istek && !vb_istek) bb_istek = 1'b1;
        bb_adres = badr;
        vb_adres = vadr;
        vb_veri  = vdat;
        vb_maske = vmask;
        vb_yaz   = vyaz;
        bel_hazir = 1'($urandom_range(0, 1));
        bel_veri  = $urandom;

        w_veri = (bb_istek && vb_istek) ? !son_veri_m : vb_istek;
        son_veri_m = w_veri;
        e_yaz = w_veri && vyaz;
        e_adr = w_veri ? vadr : badr;
        e_dat = vdat;
        e_msk = e_yaz ? vmask : {SW{1'b1}};
        tmo   = (d > ZA);
        e_out = (tmo || e_yaz) ? '0 : mdat;

        step;
        for (int k = 1; k <= ZA; k++) begin
            kontrol("serve bel_istek", bel_istek_o, 1);
            kontrol("serve bel_adres", bel_adres_o, e_adr);
            kontrol("serve bel_yaz", bel_yaz_o, e_yaz);
            kontrol("serve bel_maske", bel_maske_o, e_msk);
            if (e_yaz) kontrol("serve bel_veri", bel_veri_o, e_dat);
            kontrol("serve hazir", {bb_hazir_o, vb_hazir_o, zaman_asimi_o}, 0);
            bb_adres  = $urandom;
            vb_adres  = $urandom;
            vb_veri   = $urandom;
            vb_maske  = SW'($urandom);
            vb_yaz    = 1'($urandom);
            bel_hazir = (k == d);
            bel_veri  = (k == d) ? mdat : $urandom;
            step;
            if (k == d) break;
        end

        kontrol("done bel_istek", bel_istek_o, 0);
        kontrol("done bb_hazir", bb_hazir_o, !w_veri);
        kontrol("done vb_hazir", vb_hazir_o, w_veri);
        kontrol("done zaman_asimi", zaman_asimi_o, tmo);
        kontrol("done bb_veri", bb_veri_o, w_veri ? '0 : e_out);
        kontrol("done vb_veri", vb_veri_o, w_veri ? e_out : '0);
        if (w_veri) vb_istek = 1'b0;
        else        bb_istek = 1'b0;
        bel_hazir = 1'($urandom_range(0, 1));
        bel_veri  = $urandom;
        step;

        check_quiet("after");
        bel_hazir = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bb_istek = 0; bb_adres = 0;
        vb_istek = 0; vb_yaz = 0; vb_adres = 0; vb_veri = 0; vb_maske = 0;
        bel_veri = 0; bel_hazir = 0;
        son_veri_m = 1'b0;
        step;
        step;
        check_quiet("reset");
        kontrol("reset bel_bus", {bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o}, 0);
        rst = 1'b0;
        idle(2);

        // Instruction read, memory answers in the third high cycle.
        txn(1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 3, 32'hDEADBEEF);
        // Tie after an instruction grant: data side first, then the held instruction request.
        txn(1, 1, 32'h40, 32'h100, 32'h0, 4'h0, 0, 1, 32'h11112222);
        txn(0, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 1, 32'h33334444);
        // Continuous contention: grants must alternate.
        for (int i = 0; i < 6; i++)
            txn(1, 1, 32'h1000 + i, 32'h2000 + i, $urandom, 4'hF, 0, 1, $urandom);
        if (bb_istek || vb_istek) txn(0, 0, 32'h1F00, 32'h2F00, 32'h0, 4'hF, 0, 1, $urandom);
        // Data write with partial mask.
        txn(0, 1, 32'h0, 32'h200, 32'hCAFEF00D, 4'b0011, 1, 2, 32'h55555555);
        // Timeout, then answer exactly in the last permitted cycle.
        txn(1, 0, 32'h300, 32'h0, 32'h0, 4'h0, 0, ZA + 1, 32'h66666666);
        txn(1, 0, 32'h304, 32'h0, 32'h0, 4'h0, 0, ZA, 32'h77777777);
        txn(0, 1, 32'h0, 32'h308, 32'h0, 4'h0, 1, ZA + 3, 32'h0);

        for (int i = 0; i < 200; i++) begin
            if (!bb_istek && !vb_istek && ($urandom_range(0, 3) == 0))
                idle($urandom_range(1, 3));
            txn(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, SW'($urandom),
                1'($urandom), $urandom_range(1, ZA + 4), $urandom);
        end

        // Reset while serving a data request.
        vb_istek = 1'b1; bb_istek = 1'b0;
        vb_adres = 32'h400; vb_yaz = 1'b0;
        step;
        kontrol("pre-reset bel_istek", bel_istek_o, 1);
        step;
        rst = 1'b1;
        bel_hazir = 1'b1;
        bel_veri = 32'hABCDABCD;
        step;
        check_quiet("mid-reset");
        kontrol("mid-reset bel_bus", {bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o}, 0);
        rst = 1'b0;
        bel_hazir = 1'b0;
        vb_istek = 1'b0;
        son_veri_m = 1'b0;
        txn(1, 1, 32'h500, 32'h504, 32'h0, 4'h0, 0, 2, 32'h12345678);
        txn(0, 0, 32'h500, 32'h504, 32'h0, 4'h0, 0, 2, 32'h9ABCDEF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
